// File: rtl/element_wise_cvt_sched.sv
// element_wise_cvt_sched
//   Shares one element-wise output conversion cell (fp32 -> S33 or bypass)
//   among NUM_REQ requesters. Requesters are arbitrated round-robin. Each
//   accepted word is issued to the cell, tagged with its requester ID. Results
//   return on one valid/ready stream that carries the originating ID.
//   The cell cannot stall. A credit counter therefore guarantees that every
//   issued word has a free slot in the result FIFO.
//
// Ports
//   aclk, areset          clock, synchronous active-high reset
//   s_req_data/pass/valid per-requester operand, bypass flag and valid
//   s_req_ready           one-hot grant (all zero when out of credit)
//   cvt_cell_i_*          issue side of the conversion cell (registered)
//   cvt_cell_o_*          result side of the conversion cell
//   m_res_data/id/valid   result stream, show-ahead from the result FIFO
//   m_res_ready           result stream ready
//   busy                  a word is issued, in the cell, or buffered
//   err_ovf               sticky overflow / unexpected-result flag
//
// Optional feature: define ELM_CVT_SCHED_ERR_CHK_EN to build the err_ovf
// checks. When it is undefined, err_ovf is tied low.
//
// Handshake semantics (both streams): a transfer happens on a rising edge
// where valid and ready are both high. s_req_ready depends combinationally on
// s_req_valid, but valid never depends on ready. A requester may drop valid
// before it is granted.
module element_wise_cvt_sched #(
  parameter int NUM_REQ        = 4,
  parameter int RES_FIFO_DEPTH = 8,
  parameter int SIM_DELAY      = 1,
  localparam int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [NUM_REQ*32-1:0] s_req_data,
  input  logic [NUM_REQ-1:0]    s_req_pass,
  input  logic [NUM_REQ-1:0]    s_req_valid,
  output logic [NUM_REQ-1:0]    s_req_ready,
  output logic [31:0]           cvt_cell_i_op_x,
  output logic                  cvt_cell_i_pass,
  output logic [ID_W-1:0]       cvt_cell_i_info_along,
  output logic                  cvt_cell_i_vld,
  input  logic [31:0]           cvt_cell_o_res,
  input  logic [ID_W-1:0]       cvt_cell_o_info_along,
  input  logic                  cvt_cell_o_vld,
  output logic [31:0]           m_res_data,
  output logic [ID_W-1:0]       m_res_id,
  output logic                  m_res_valid,
  input  logic                  m_res_ready,
  output logic                  busy,
  output logic                  err_ovf
);

  localparam int AW = $clog2(RES_FIFO_DEPTH);
  localparam int CW = $clog2(RES_FIFO_DEPTH + 1);
  localparam int FW = ID_W + 32;

  // Registered assignments carry no delay in this model, so SIM_DELAY is only
  // range-checked alongside the other parameters.
  if (NUM_REQ < 2 || NUM_REQ > 16 || RES_FIFO_DEPTH < 2 ||
      (RES_FIFO_DEPTH & (RES_FIFO_DEPTH - 1)) != 0 || SIM_DELAY < 0) begin : g_param_chk
    $error("element_wise_cvt_sched: illegal parameter combination");
  end

  logic [31:0]     req_word [NUM_REQ];
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_found;
  logic            hs;
  logic [CW-1:0]   crd;
  logic [CW-1:0]   inf;
  logic            inf_ret;
  logic            pop;
  logic            wr_en;
  logic            empty;
  logic            full;
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [FW-1:0]   mem [RES_FIFO_DEPTH];
  logic [FW-1:0]   head;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_word[i] = s_req_data[32*i +: 32];
  end

  // Search NUM_REQ positions circularly from rr_ptr. The first valid one wins.
  always_comb begin : p_arb
    logic [ID_W:0] idx;
    idx       = '0;
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (!gnt_found && s_req_valid[idx[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_id    = idx[ID_W-1:0];
      end
    end
  end

  // A pop in this cycle does not add to crd here. The freed credit is used
  // from the next cycle on, which keeps the ready path short.
  assign hs = gnt_found && (crd != '0) && !areset;

  always_comb begin
    s_req_ready = '0;
    if (hs) s_req_ready[gnt_id] = 1'b1;
  end

  // Results are accepted only when this block has words outstanding in the
  // cell. Words issued before a reset come back while inf == 0 and are
  // dropped here.
  assign inf_ret = cvt_cell_o_vld && (inf != '0);
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && m_res_ready;
  assign wr_en   = inf_ret && (!full || pop);

  always_ff @(posedge aclk) begin
    if (areset) begin
      rr_ptr                <= '0;
      crd                   <= CW'(RES_FIFO_DEPTH);
      inf                   <= '0;
      cvt_cell_i_vld        <= 1'b0;
      cvt_cell_i_op_x       <= '0;
      cvt_cell_i_pass       <= 1'b0;
      cvt_cell_i_info_along <= '0;
      wr_ptr                <= '0;
      rd_ptr                <= '0;
    end else begin
      cvt_cell_i_vld <= hs;
      if (hs) begin
        rr_ptr                <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
        cvt_cell_i_op_x       <= req_word[gnt_id];
        cvt_cell_i_pass       <= s_req_pass[gnt_id];
        cvt_cell_i_info_along <= gnt_id;
      end
      if (hs && !pop)      crd <= crd - CW'(1);
      else if (!hs && pop) crd <= crd + CW'(1);
      if (hs && !inf_ret)      inf <= inf + CW'(1);
      else if (!hs && inf_ret) inf <= inf - CW'(1);
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // The storage has no reset. The outputs are forced to zero while the FIFO
  // is empty.
  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {cvt_cell_o_info_along, cvt_cell_o_res};
  end

  assign head        = mem[rd_ptr[AW-1:0]];
  assign m_res_valid = !empty;
  assign m_res_data  = empty ? '0 : head[31:0];
  assign m_res_id    = empty ? '0 : head[FW-1:32];
  assign busy        = (inf != '0) || !empty || cvt_cell_i_vld;

`ifdef ELM_CVT_SCHED_ERR_CHK_EN
  logic err_q;
  always_ff @(posedge aclk) begin
    if (areset) err_q <= 1'b0;
    else if (cvt_cell_o_vld && ((full && !pop) || (inf == '0))) err_q <= 1'b1;
  end
  assign err_ovf = err_q;
`else
  assign err_ovf = 1'b0;
`endif

endmodule
